sd_emmc_clock_gen: RTL and testbench

Parametrised SD/eMMC card-clock generator for the host controller, driven from the AXI clock domain. It divides AXI_CLOCK by a programmable divisor to produce sd_clk and a quarter-period-lagged sd_clk90. Gating, divisor reloads and internal-clock-enable handling are all glitch-free. It also emits single-cycle rise/fall strobes so the CMD/DAT engines can run entirely on AXI_CLOCK with clock enables.

---
 rtl/sd_emmc_clock_gen_pkg.sv | 13 +
 rtl/sd_emmc_clock_gen_phase_delay.sv | 62 ++++++
 rtl/sd_emmc_clock_gen.sv | 147 ++++++++++++++
 tb/tb_sd_emmc_clock_gen.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_emmc_clock_gen_pkg.sv
// Shared types for the SD/eMMC card-clock generator.
package sd_emmc_clk_pkg;

   localparam int DIV_W_DEFAULT = 10;

   typedef enum logic [1:0] {
      OFF    = 2'd0,
      WARMUP = 2'd1,
      GATED  = 2'd2,
      RUN    = 2'd3
   } clk_state_e;

endpackage

// File: rtl/sd_emmc_clock_gen_phase_delay.sv
// Reproduces each edge of a registered clock a programmable number of cycles later.
module sd_emmc_phase_delay
   import sd_emmc_clk_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             edge_req,
   input  logic             level_next,
   input  logic [DIV_W-1:0] lag,
   output logic             clk_lagged
);

   logic [DIV_W-1:0] dly_q, dly_d;
   logic             pend_q, pend_d;
   logic             tgt_q, tgt_d;
   logic             out_q, out_d;

   always_comb begin
      dly_d  = dly_q;
      pend_d = pend_q;
      tgt_d  = tgt_q;
      out_d  = out_q;
      if (pend_q) begin
         if (dly_q == '0) begin
            out_d  = tgt_q;
            pend_d = 1'b0;
         end else begin
            dly_d = dly_q - 1'b1;
         end
      end
      // zero lag follows the source edge in the same cycle
      if (edge_req) begin
         if (lag == '0) begin
            out_d  = level_next;
            pend_d = 1'b0;
         end else begin
            pend_d = 1'b1;
            tgt_d  = level_next;
            dly_d  = lag - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dly_q  <= '0;
         pend_q <= 1'b0;
         tgt_q  <= 1'b0;
         out_q  <= 1'b0;
      end else begin
         dly_q  <= dly_d;
         pend_q <= pend_d;
         tgt_q  <= tgt_d;
         out_q  <= out_d;
      end
   end

   assign clk_lagged = out_q;

endmodule

// File: rtl/sd_emmc_clock_gen.sv
// SD/eMMC card-clock generator: divided sd_clk, lagged sd_clk90 and edge strobes on AXI_CLOCK.
module sd_emmc_clock_gen
   import sd_emmc_clk_pkg::*;
#(
   parameter int DIV_W         = DIV_W_DEFAULT,
   parameter int STABLE_CYCLES = 8
) (
   input  logic             AXI_CLOCK,
   input  logic             AXI_RST,
   input  logic             int_clk_en,
   input  logic             sd_clk_en,
   input  logic [DIV_W-1:0] DIVISOR,
   output logic             sd_clk,
   output logic             sd_clk90,
   output logic             sd_clk_rise,
   output logic             sd_clk_fall,
   output logic             Internal_clk_stable,
   output logic             sd_clk_running,
   output logic [DIV_W-1:0] cur_div
);

   localparam int WC_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

   clk_state_e       state_q, state_d, stop_state;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] cur_div_q, cur_div_d;
   logic [WC_W-1:0]  wcnt_q, wcnt_d;
   logic             clk_q, clk_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic             stable_q, stable_d;
   logic             toggle, stop_req;
   logic [DIV_W-1:0] lag;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      cur_div_d  = cur_div_q;
      wcnt_d     = wcnt_q;
      clk_d      = clk_q;
      stable_d   = stable_q;
      rise_d     = 1'b0;
      fall_d     = 1'b0;
      toggle     = (cnt_q == cur_div_q);
      stop_req   = !sd_clk_en || !int_clk_en;
      stop_state = int_clk_en ? GATED : OFF;
      unique case (state_q)
         OFF: begin
            cnt_d    = '0;
            wcnt_d   = '0;
            clk_d    = 1'b0;
            stable_d = 1'b0;
            if (int_clk_en) state_d = WARMUP;
         end
         WARMUP: begin
            if (!int_clk_en) begin
               state_d = OFF;
               wcnt_d  = '0;
            end else if (wcnt_q == WC_W'(STABLE_CYCLES - 1)) begin
               state_d  = GATED;
               stable_d = 1'b1;
               wcnt_d   = '0;
            end else begin
               wcnt_d = wcnt_q + 1'b1;
            end
         end
         GATED: begin
            cnt_d     = '0;
            clk_d     = 1'b0;
            cur_div_d = DIVISOR;
            if (!int_clk_en) begin
               state_d  = OFF;
               stable_d = 1'b0;
            end else if (sd_clk_en) begin
               state_d = RUN;
            end
         end
         RUN: begin
            // a stop while low leaves at once unless a rise is due this edge
            if (stop_req && !clk_q && !toggle) begin
               state_d = stop_state;
               cnt_d   = '0;
               if (!int_clk_en) stable_d = 1'b0;
            end else if (toggle) begin
               cnt_d = '0;
               clk_d = !clk_q;
               if (!clk_q) begin
                  cur_div_d = DIVISOR;
                  rise_d    = 1'b1;
               end else begin
                  fall_d = 1'b1;
                  if (stop_req) begin
                     state_d = stop_state;
                     if (!int_clk_en) stable_d = 1'b0;
                  end
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge AXI_CLOCK) begin
      if (AXI_RST) begin
         state_q   <= OFF;
         cnt_q     <= '0;
         cur_div_q <= '0;
         wcnt_q    <= '0;
         clk_q     <= 1'b0;
         rise_q    <= 1'b0;
         fall_q    <= 1'b0;
         stable_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         cur_div_q <= cur_div_d;
         wcnt_q    <= wcnt_d;
         clk_q     <= clk_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
         stable_q  <= stable_d;
      end
   end

   // lag for the phase that starts at this edge uses the divisor in effect for it
   assign lag = DIV_W'(({1'b0, cur_div_d} + {{DIV_W{1'b0}}, 1'b1}) >> 1);

   sd_emmc_phase_delay #(
      .DIV_W(DIV_W)
   ) u_phase_delay (
      .clk       (AXI_CLOCK),
      .rst       (AXI_RST),
      .edge_req  (clk_d != clk_q),
      .level_next(clk_d),
      .lag       (lag),
      .clk_lagged(sd_clk90)
   );

   assign sd_clk              = clk_q;
   assign sd_clk_rise         = rise_q;
   assign sd_clk_fall         = fall_q;
   assign Internal_clk_stable = stable_q;
   assign sd_clk_running      = (state_q == RUN);
   assign cur_div             = cur_div_q;

endmodule

// File: tb/tb_sd_emmc_clock_gen.sv
// Scoreboard bench: stimulus predicts each sd_clk period, a monitor measures and compares.
module tb_sd_emmc_clock_gen;

   localparam int DW = 10;
   localparam int SC = 8;

   logic          AXI_CLOCK = 1'b0;
   logic          AXI_RST;
   logic          int_clk_en;
   logic          sd_clk_en;
   logic [DW-1:0] DIVISOR;
   logic          sd_clk, sd_clk90, sd_clk_rise, sd_clk_fall;
   logic          Internal_clk_stable, sd_clk_running;
   logic [DW-1:0] cur_div;

   always #5 AXI_CLOCK = ~AXI_CLOCK;

   sd_emmc_clock_gen #(
      .DIV_W        (DW),
      .STABLE_CYCLES(SC)
   ) dut (
      .AXI_CLOCK          (AXI_CLOCK),
      .AXI_RST            (AXI_RST),
      .int_clk_en         (int_clk_en),
      .sd_clk_en          (sd_clk_en),
      .DIVISOR            (DIVISOR),
      .sd_clk             (sd_clk),
      .sd_clk90           (sd_clk90),
      .sd_clk_rise        (sd_clk_rise),
      .sd_clk_fall        (sd_clk_fall),
      .Internal_clk_stable(Internal_clk_stable),
      .sd_clk_running     (sd_clk_running),
      .cur_div            (cur_div)
   );

   typedef struct {
      int hi;
      int lo;
      int h;
      bit last;
   } per_t;

   per_t sbq[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   int   cur    = 0;
   bit   mon_on = 1'b0;

   always @(posedge AXI_CLOCK) cyc <= cyc + 1;

   function automatic void chk(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   // Expected period for divisor n: equal halves of n+1, quadrature lag (n+1)/2.
   task automatic push(input int n, input bit last);
      per_t e;
      e.hi = n + 1;
      e.lo = n + 1;
      e.h  = (n + 1) / 2;
      e.last = last;
      sbq.push_back(e);
   endtask

   // ---------------- monitor ----------------
   bit p_clk = 1'b0, p_90 = 1'b0;
   bit in_per = 1'b0, got_fall, got_r90, got_f90;
   int rise_t, fall_t, r90_t, f90_t;

   task automatic finalize(input bit is_last);
      per_t e;
      if (sbq.size() == 0) begin
         chk("scoreboard_empty", 0, 1);
      end else begin
         e = sbq.pop_front();
         chk("period_last_flag", is_last, e.last);
         chk("high_len", fall_t - rise_t, e.hi);
         if (!is_last) chk("low_len", cyc - fall_t, e.lo);
         chk("clk90_rise_lag", got_r90 ? r90_t - rise_t : -1, e.h);
         chk("clk90_fall_lag", got_f90 ? f90_t - fall_t : -1, e.h);
      end
      in_per = 1'b0;
   endtask

   initial begin : monitor
      bit rise_e, fall_e, r90, f90;
      forever begin
         @(negedge AXI_CLOCK);
         if (mon_on) begin
            rise_e = sd_clk && !p_clk;
            fall_e = !sd_clk && p_clk;
            r90    = sd_clk90 && !p_90;
            f90    = !sd_clk90 && p_90;
            chk("rise_strobe", sd_clk_rise, rise_e);
            chk("fall_strobe", sd_clk_fall, fall_e);
            if (sd_clk && !sd_clk_running) chk("clk_high_outside_run", 1, 0);
            if (rise_e) begin
               if (in_per) finalize(1'b0);
               in_per   = 1'b1;
               rise_t   = cyc;
               got_fall = 1'b0;
               got_r90  = 1'b0;
               got_f90  = 1'b0;
            end
            if (fall_e && in_per) begin
               fall_t   = cyc;
               got_fall = 1'b1;
            end
            if (r90 && in_per) begin
               r90_t   = cyc;
               got_r90 = 1'b1;
            end
            if (f90 && in_per && got_fall) begin
               f90_t   = cyc;
               got_f90 = 1'b1;
            end
            if (in_per && got_fall && got_f90 && !sd_clk_running) finalize(1'b1);
         end else begin
            in_per = 1'b0;
         end
         p_clk = sd_clk;
         p_90  = sd_clk90;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge AXI_CLOCK);
      #1;
   endtask

   task automatic wait_rise();
      bit ok = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         tick();
         if (sd_clk_rise) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("rise_timeout", 0, 1);
   endtask

   task automatic wait_fall();
      bit ok = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         tick();
         if (sd_clk_fall) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("fall_timeout", 0, 1);
   endtask

   task automatic wait_stopped();
      bit ok = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         tick();
         if (!sd_clk_running) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("stop_timeout", 0, 1);
   endtask

   task automatic settle();
      repeat (cur / 2 + 3) tick();
      chk("held_low", {30'd0, sd_clk, sd_clk90}, 0);
   endtask

   task automatic warmup();
      int n = 0;
      bit ok = 1'b0;
      int_clk_en = 1'b1;
      tick();
      for (int i = 0; i < 100; i++) begin
         tick();
         n++;
         if (Internal_clk_stable) begin
            ok = 1'b1;
            break;
         end
      end
      chk("warmup_cycles", ok ? n : -1, SC);
      chk("warmup_clk_low", sd_clk, 0);
      chk("warmup_not_running", sd_clk_running, 0);
   endtask

   // Enable from GATED with divisor n; returns in the first cycle sd_clk reads 1.
   task automatic enable_first(input int n);
      int  k = 0;
      bit  ok = 1'b0;
      DIVISOR = DW'(n);
      tick();
      tick();
      chk("gated_div_load", int'(cur_div), n);
      sd_clk_en = 1'b1;
      tick();
      chk("run_entry", sd_clk_running, 1);
      for (int i = 0; i < 3000; i++) begin
         tick();
         k++;
         if (sd_clk_rise) begin
            ok = 1'b1;
            break;
         end
      end
      chk("first_rise_delay", ok ? k : -1, n + 1);
      cur = n;
   endtask

   task automatic stop_after_rise();
      push(cur, 1'b1);
      sd_clk_en = 1'b0;
      wait_stopped();
      settle();
   endtask

   function automatic int pick_n();
      if ($urandom_range(0, 9) < 2) return 0;
      return int'($urandom_range(1, 12));
   endfunction

   task automatic random_step();
      int act = int'($urandom_range(0, 99));
      int nn  = cur;
      if (act < 12) begin
         stop_after_rise();
         enable_first(pick_n());
      end else if (act < 22 && cur >= 1) begin
         push(cur, 1'b1);
         wait_fall();
         sd_clk_en = 1'b0;
         tick();
         chk("low_stop_immediate", sd_clk_running, 0);
         settle();
         enable_first(pick_n());
      end else begin
         push(cur, 1'b0);
         if (act < 55) begin
            nn = pick_n();
            DIVISOR = DW'(nn);
         end
         wait_rise();
         cur = nn;
      end
   endtask

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   initial begin : stimulus
      AXI_RST    = 1'b1;
      int_clk_en = 1'b0;
      sd_clk_en  = 1'b0;
      DIVISOR    = '0;
      repeat (3) tick();
      AXI_RST = 1'b0;
      tick();
      chk("rst_sd_clk", sd_clk, 0);
      chk("rst_sd_clk90", sd_clk90, 0);
      chk("rst_rise", sd_clk_rise, 0);
      chk("rst_fall", sd_clk_fall, 0);
      chk("rst_stable", Internal_clk_stable, 0);
      chk("rst_running", sd_clk_running, 0);
      chk("rst_cur_div", int'(cur_div), 0);
      mon_on = 1'b1;

      DIVISOR = 4;
      warmup();
      enable_first(4);

      // divisor change in the high phase applies from the next rise
      tick();
      tick();
      DIVISOR = 1;
      push(4, 1'b0);
      tick();
      chk("cur_div_hold", int'(cur_div), 4);
      wait_rise();
      chk("cur_div_at_rise", int'(cur_div), 1);
      cur = 1;

      DIVISOR = 3;
      push(1, 1'b0);
      wait_rise();
      cur = 3;
      stop_after_rise();

      enable_first(pick_n());
      for (int it = 0; it < 40; it++) random_step();
      stop_after_rise();

      enable_first(1023);
      push(1023, 1'b0);
      wait_rise();
      stop_after_rise();

      enable_first(0);
      for (int it = 0; it < 3; it++) begin
         push(0, 1'b0);
         wait_rise();
      end

      // internal clock disable while running
      push(0, 1'b1);
      int_clk_en = 1'b0;
      wait_stopped();
      chk("int_off_stable", Internal_clk_stable, 0);
      sd_clk_en = 1'b0;
      settle();

      warmup();
      enable_first(4);
      tick();
      tick();
      mon_on  = 1'b0;
      AXI_RST = 1'b1;
      tick();
      chk("midrst_sd_clk", sd_clk, 0);
      chk("midrst_sd_clk90", sd_clk90, 0);
      chk("midrst_rise", sd_clk_rise, 0);
      chk("midrst_fall", sd_clk_fall, 0);
      chk("midrst_stable", Internal_clk_stable, 0);
      chk("midrst_running", sd_clk_running, 0);
      chk("midrst_cur_div", int'(cur_div), 0);
      AXI_RST = 1'b0;
      tick();
      chk("scoreboard_drained", sbq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
